// File: rtl/clk_div_sched.sv
// clk_div_sched: CH-channel runtime-configurable clock divider whose reconfiguration lands on period boundaries; define CLK_DIV_SYNC_EN to add the sync_all phase-align input
module clk_div_sched #(
  parameter int CH = 4,
  parameter int CH_W = 2,
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 1000,
  parameter logic [CH-1:0] RESET_EN = '1
) (
  input  logic I_CLK,
  input  logic rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic sync_all,
`endif
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic cfg_en,
  output logic cfg_done,
  output logic [CH-1:0] O_CLK,
  output logic [CH-1:0] O_TICK
);
  localparam int NSEL = 1 << CH_W;
  localparam logic [NSEL-1:0] CH_OK = {NSEL{1'b1}} >> (NSEL - CH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt [CH];
  logic [CNT_W-1:0] div_act [CH];
  logic [CH-1:0] en_act, tc, apply;
  logic [CH_W-1:0] shd_ch;
  logic [CNT_W-1:0] shd_div;
  logic shd_en, sync;
`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_all;
`else
  assign sync = 1'b0;
`endif
  assign cfg_ready = state == IDLE;
  // terminal count per channel and the cycle on which the pending request lands on its target
  always_comb begin
    tc = '0;
    apply = '0;
    for (int i = 0; i < CH; i++) begin
      tc[i] = en_act[i] && !sync && cnt[i] == div_act[i] - 1'b1;
      apply[i] = state == WAIT && shd_ch == CH_W'(i) && (!en_act[i] || (tc[i] && (shd_en || O_CLK[i])));
    end
  end
  // per-channel counters, divided clocks and tick strobes; a disable only lands on a falling toggle
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
        div_act[i] <= CNT_W'(DEFAULT_DIV);
      end
      en_act <= RESET_EN;
      O_CLK <= '0;
      O_TICK <= '0;
    end else begin
      O_TICK <= tc;
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= (!en_act[i] || sync || tc[i]) ? '0 : cnt[i] + 1'b1;
        O_CLK[i] <= (!en_act[i] || sync) ? 1'b0 : O_CLK[i] ^ tc[i];
        if (apply[i]) begin
          div_act[i] <= shd_div;
          en_act[i] <= shd_en;
        end
      end
    end
  end
  // request FSM; cfg_done is registered out of the DONE state, a zero ratio counts as a disable
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cfg_done <= 1'b0;
      shd_ch <= '0;
      shd_div <= '0;
      shd_en <= 1'b0;
    end else begin
      cfg_done <= state == DONE;
      case (state)
        IDLE: if (cfg_valid) begin
          shd_ch <= cfg_ch;
          shd_div <= cfg_div;
          shd_en <= cfg_en && cfg_div != '0;
          state <= CH_OK[cfg_ch] ? WAIT : DONE;
        end
        WAIT: if (|apply) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: directed self-checking bench for clk_div_sched
module tb_clk_div_sched;
  logic I_CLK = 1'b0, rst = 1'b0, rst2 = 1'b0;
  logic cv1 = 1'b0, ce1 = 1'b0, cv2 = 1'b0, ce2 = 1'b0;
  logic [1:0] cc1 = '0, cc2 = '0;
  logic [15:0] cd1 = '0, cd2 = '0;
  logic rdy1, done1, rdy2, done2;
  logic [3:0] oclk1, otick1;
  logic [2:0] oclk2, otick2;
  int n_chk = 0, n_err = 0;

  typedef struct {int t; logic [1:0] ch; logic [15:0] div; logic en; int done_at;} req_t;
  typedef struct {int u; logic v; logic [1:0] ch; logic [15:0] div; logic en;
                  logic [2:0] clk; logic [2:0] tick; logic done; logic rdy;} vec_t;
  req_t rq[4];
  vec_t vt[17];

  always #5 I_CLK = ~I_CLK;

  clk_div_sched u_dut (
    .I_CLK(I_CLK), .rst(rst),
`ifdef CLK_DIV_SYNC_EN
    .sync_all(1'b0),
`endif
    .cfg_valid(cv1), .cfg_ready(rdy1), .cfg_ch(cc1), .cfg_div(cd1), .cfg_en(ce1),
    .cfg_done(done1), .O_CLK(oclk1), .O_TICK(otick1)
  );

  clk_div_sched #(.CH(3), .CH_W(2), .CNT_W(16), .DEFAULT_DIV(4), .RESET_EN(3'b011)) u_dut3 (
    .I_CLK(I_CLK), .rst(rst2),
`ifdef CLK_DIV_SYNC_EN
    .sync_all(1'b0),
`endif
    .cfg_valid(cv2), .cfg_ready(rdy2), .cfg_ch(cc2), .cfg_div(cd2), .cfg_en(ce2),
    .cfg_done(done2), .O_CLK(oclk2), .O_TICK(otick2)
  );

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic lvl(int t, int s, int h, logic l0);
    return l0 ^ ((((t - s) / h) % 2) != 0);
  endfunction

  function automatic logic tk(int t, int s, int h);
    return t >= s && (t - s) % h == 0;
  endfunction

  // hand-derived channel timelines of the main instance for the request schedule in rq
  function automatic logic [3:0] ex_clk(int t);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = t >= 1000 && lvl(t, 1000, 1000, 1'b1);
    if (t >= 6000) r[1] = lvl(t, 6000, 10, 1'b0);
    if (t >= 8000) r[2] = 1'b0;
    if (t >= 10000) r[3] = t >= 10006 && lvl(t, 10006, 3, 1'b1);
    return r;
  endfunction

  function automatic logic [3:0] ex_tick(int t);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = tk(t, 1000, 1000);
    if (t >= 6000) r[1] = tk(t, 6000, 10);
    if (t > 8000) r[2] = 1'b0;
    if (t > 10000) r[3] = tk(t, 10006, 3);
    return r;
  endfunction

  initial begin
    int bad_clk, bad_tick, bad_rdy, bad_done, fb_clk, bad2, u;
    int seen[4];
    logic er, ed;
    rq[0] = '{5400, 2'd1, 16'd10, 1'b1, 6001};
    rq[1] = '{6100, 2'd2, 16'd5, 1'b0, 8001};
    rq[2] = '{8200, 2'd3, 16'd7, 1'b0, 10001};
    rq[3] = '{10001, 2'd3, 16'd3, 1'b1, 10004};
    vt[0]  = '{0,  1'b1, 2'd3, 16'd9, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1};
    vt[1]  = '{1,  1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[2]  = '{2,  1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1};
    vt[3]  = '{3,  1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};
    vt[4]  = '{4,  1'b0, 2'd0, 16'd0, 1'b0, 3'b011, 3'b011, 1'b0, 1'b1};
    vt[5]  = '{8,  1'b1, 2'd1, 16'd0, 1'b1, 3'b000, 3'b011, 1'b0, 1'b1};
    vt[6]  = '{9,  1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[7]  = '{12, 1'b0, 2'd0, 16'd0, 1'b0, 3'b011, 3'b011, 1'b0, 1'b0};
    vt[8]  = '{13, 1'b0, 2'd0, 16'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0};
    vt[9]  = '{16, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0};
    vt[10] = '{17, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1};
    vt[11] = '{20, 1'b1, 2'd2, 16'd1, 1'b1, 3'b001, 3'b001, 1'b0, 1'b1};
    vt[12] = '{21, 1'b0, 2'd0, 16'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0};
    vt[13] = '{22, 1'b0, 2'd0, 16'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0};
    vt[14] = '{23, 1'b0, 2'd0, 16'd0, 1'b0, 3'b101, 3'b100, 1'b1, 1'b1};
    vt[15] = '{24, 1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b101, 1'b0, 1'b1};
    vt[16] = '{25, 1'b0, 2'd0, 16'd0, 1'b0, 3'b100, 3'b100, 1'b0, 1'b1};
    bad_clk = 0; bad_tick = 0; bad_rdy = 0; bad_done = 0; fb_clk = -1; bad2 = 0;
    for (int r = 0; r < 4; r++) seen[r] = -1;
    // reset values while held in reset
    repeat (3) step();
    chk("reset_oclk", oclk1, 4'h0);
    chk("reset_otick", otick1, 4'h0);
    chk("reset_done", done1, 1'b0);
    chk("reset_ready", rdy1, 1'b1);
    rst = 1'b1;
    // main instance: defaults, ratio change, two disables, enable with div 3
    for (int t = 1; t <= 10100; t++) begin
      step();
      er = 1'b1;
      ed = 1'b0;
      for (int r = 0; r < 4; r++) begin
        if (t > rq[r].t && t < rq[r].done_at) er = 1'b0;
        if (t == rq[r].done_at) ed = 1'b1;
        if (done1 && seen[r] < 0 && t > rq[r].t) seen[r] = t;
      end
      if (oclk1 !== ex_clk(t)) begin
        bad_clk++;
        if (fb_clk < 0) fb_clk = t;
      end
      if (otick1 !== ex_tick(t)) bad_tick++;
      if (rdy1 !== er) bad_rdy++;
      if (done1 !== ed) bad_done++;
      cv1 = 1'b0;
      for (int r = 0; r < 4; r++)
        if (rq[r].t == t) begin
          cv1 = 1'b1; cc1 = rq[r].ch; cd1 = rq[r].div; ce1 = rq[r].en;
        end
    end
    chk($sformatf("run_oclk_bad_cycles first_t=%0d", fb_clk), bad_clk, 0);
    chk("run_otick_bad_cycles", bad_tick, 0);
    chk("run_ready_bad_cycles", bad_rdy, 0);
    chk("run_done_bad_cycles", bad_done, 0);
    for (int r = 0; r < 4; r++) chk($sformatf("req%0d_done_at", r), seen[r], rq[r].done_at);
    // reset asserted while a ratio change waits for its boundary
    cv1 = 1'b1; cc1 = 2'd0; cd1 = 16'd2; ce1 = 1'b1;
    step();
    cv1 = 1'b0;
    repeat (9) step();
    chk("wait_ready", rdy1, 1'b0);
    chk("wait_oclk", oclk1, 4'b1010);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_oclk", oclk1, 4'h0);
    chk("async_reset_otick", otick1, 4'h0);
    chk("async_reset_done", done1, 1'b0);
    chk("async_reset_ready", rdy1, 1'b1);
    step();
    step();
    rst = 1'b1;
    for (int t = 1; t <= 1100; t++) begin
      step();
      if (oclk1 !== ex_clk(t) || otick1 !== ex_tick(t) || done1 !== 1'b0 || rdy1 !== 1'b1) bad2++;
    end
    chk("after_reset_bad_cycles", bad2, 0);
    // 3-channel instance: invalid channel, zero ratio, div 1
    rst2 = 1'b1;
    u = 0;
    for (int i = 0; i < 17; i++) begin
      while (u < vt[i].u) begin
        step();
        u++;
      end
      chk($sformatf("v%0d_oclk", vt[i].u), oclk2, vt[i].clk);
      chk($sformatf("v%0d_otick", vt[i].u), otick2, vt[i].tick);
      chk($sformatf("v%0d_done", vt[i].u), done2, vt[i].done);
      chk($sformatf("v%0d_ready", vt[i].u), rdy2, vt[i].rdy);
      cv2 = vt[i].v; cc2 = vt[i].ch; cd2 = vt[i].div; ce2 = vt[i].en;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
